// File: rtl/ram_controller.sv
// ram_controller: valid/ready request front end driving a single-port Ram with one-cycle access strobes.
// Define RAM_CTRL_BYTE_MASK_EN to honour req_mask through read-modify-write stores.
module ram_controller #(
   parameter int DATA_SIZE    = 32,
   parameter int ADDRESS_SIZE = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDRESS_SIZE-1:0]   req_address,
   input  logic [DATA_SIZE-1:0]      req_wdata,
   input  logic [DATA_SIZE/8-1:0]    req_mask,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_SIZE-1:0]      rsp_rdata,
   output logic                      ram_enable,
   output logic                      ram_read_write,
   output logic [ADDRESS_SIZE-1:0]   ram_address,
   output logic [DATA_SIZE-1:0]      ram_data_in,
   input  logic [DATA_SIZE-1:0]      ram_data_out
);
   localparam int NB = DATA_SIZE / 8;
`ifdef RAM_CTRL_BYTE_MASK_EN
   typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;
`else
   typedef enum logic [2:0] {IDLE, ACCESS, RESP} state_t;
`endif
   state_t state, next, target;
   logic write_q, rmw_rd, rmw_wr;
`ifdef RAM_CTRL_BYTE_MASK_EN
   logic [NB-1:0] mask_q;
   logic [DATA_SIZE-1:0] wdata_q, merged;
   // zero-mask stores complete without touching the Ram
   assign target = (!req_write || &req_mask) ? ACCESS : (|req_mask ? RMW_RD : RESP);
   assign rmw_rd = state == RMW_RD;
   assign rmw_wr = state == RMW_WR;
   always_comb begin
      merged = ram_data_out;
      for (int i = 0; i < NB; i++)
         if (mask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
   end
`else
   logic unused_mask;
   assign unused_mask = ^req_mask;
   assign target = ACCESS;
   assign rmw_rd = 1'b0;
   assign rmw_wr = 1'b0;
`endif
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:   next = req_valid ? target : IDLE;
         ACCESS: next = RESP;
`ifdef RAM_CTRL_BYTE_MASK_EN
         RMW_RD: next = RMW_WR;
         RMW_WR: next = RESP;
`endif
         RESP:   next = rsp_ready ? IDLE : RESP;
         default: next = IDLE;
      endcase
   end
   always_comb begin
      req_ready      = state == IDLE && !reset;
      rsp_valid      = state == RESP;
      ram_enable     = state == ACCESS || rmw_rd || rmw_wr;
      ram_read_write = !((state == ACCESS && write_q) || rmw_wr);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_q     <= 1'b0;
         ram_address <= '0;
         ram_data_in <= '0;
         rsp_rdata   <= '0;
`ifdef RAM_CTRL_BYTE_MASK_EN
         mask_q      <= '0;
         wdata_q     <= '0;
`endif
      end else begin
         if (state == IDLE && req_valid) begin
            write_q <= req_write;
`ifdef RAM_CTRL_BYTE_MASK_EN
            mask_q  <= req_mask;
            wdata_q <= req_wdata;
`endif
            if (target != RESP) ram_address <= req_address;
            if (target == ACCESS) ram_data_in <= req_wdata;
         end
         if (state == ACCESS && !write_q) rsp_rdata <= ram_data_out;
`ifdef RAM_CTRL_BYTE_MASK_EN
         if (rmw_rd) ram_data_in <= merged;
`endif
      end
   end
endmodule

// File: tb/tb_ram_controller.sv
// tb_ram_controller: directed and randomized checks of ram_controller against a Ram model and a word-level reference memory.
module tb_ram_controller;
   logic        clk = 1'b0, reset = 1'b1, clear = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [15:0] req_address = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_mask = '0;
   logic        rsp_valid, rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        ram_enable, ram_read_write;
   logic [15:0] ram_address;
   logic [31:0] ram_data_in, ram_data_out;
   logic [31:0] mem [0:255];
   logic [31:0] exp_mem [0:255];
   logic [31:0] last_load;
   int total = 0, bad = 0;

   ram_controller dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_address(req_address), .req_wdata(req_wdata), .req_mask(req_mask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ram_enable(ram_enable), .ram_read_write(ram_read_write),
      .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   assign ram_data_out = mem[ram_address[7:0]];
   always @(posedge clk)
      if (clear) for (int i = 0; i < 256; i++) mem[i] <= '0;
      else if (ram_enable && !ram_read_write) mem[ram_address[7:0]] <= ram_data_in;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      r = old;
`ifdef RAM_CTRL_BYTE_MASK_EN
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
`else
      r = d;
`endif
      return r;
   endfunction

   function automatic int exp_lat(input logic w, input logic [3:0] m);
`ifdef RAM_CTRL_BYTE_MASK_EN
      return (w && m != 4'h0 && m != 4'hF) ? 2 : 1;
`else
      return 1;
`endif
   endfunction

   function automatic int exp_en(input logic w, input logic [3:0] m);
      if (!w) return 1;
`ifdef RAM_CTRL_BYTE_MASK_EN
      return m == 4'h0 ? 0 : (m == 4'hF ? 1 : 2);
`else
      return 1;
`endif
   endfunction

   task automatic xact(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                       output int lat, output int en, output int wr, output logic [31:0] rd);
      lat = -1; en = 0; wr = 0; rd = '0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_address = a; req_wdata = d; req_mask = m; rsp_ready = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (ram_enable) en++;
         if (ram_enable && !ram_read_write) wr++;
         if (rsp_valid) begin
            lat = k - 1; rd = rsp_rdata;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clear = 1'b1;
      repeat (2) @(negedge clk);
      clear = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = '0;
      last_load = '0;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      total++; if ({rsp_valid, ram_enable, ram_read_write} !== 3'b001) begin bad++; $display("FAIL reset_strobes: got %b want 001", {rsp_valid, ram_enable, ram_read_write}); end
      total++; if ({ram_address, ram_data_in, rsp_rdata} !== 80'd0) begin bad++; $display("FAIL reset_data: got %h want 0", {ram_address, ram_data_in, rsp_rdata}); end
      reset = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
   endtask

   task automatic test_abort();
      int lat, en, wr; logic [31:0] rd;
      xact(1'b1, 16'd3, 32'h12345678, 4'hF, lat, en, wr, rd);
      exp_mem[3] = 32'h12345678;
      total++; if (mem[3] !== 32'h12345678) begin bad++; $display("FAIL abort_prestore: got %h want 12345678", mem[3]); end
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_address = 16'd3; req_wdata = 32'hDEADBEEF; req_mask = 4'hF;
      @(posedge clk); #1 req_valid = 1'b0;
      #2;
      total++; if ({ram_enable, ram_read_write} !== 2'b10) begin bad++; $display("FAIL abort_in_access: got %b want 10", {ram_enable, ram_read_write}); end
      reset = 1'b1;
      #1;
      total++; if (ram_enable !== 1'b0) begin bad++; $display("FAIL abort_enable_drop: got %b want 0", ram_enable); end
      @(negedge clk);
      reset = 1'b0;
      last_load = '0;
      @(negedge clk);
      total++; if (mem[3] !== 32'h12345678) begin bad++; $display("FAIL abort_mem3: got %h want 12345678", mem[3]); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_full_store();
      int lat, en, wr; logic [31:0] rd;
      xact(1'b1, 16'd0, 32'h671A561D, 4'hF, lat, en, wr, rd);
      exp_mem[0] = 32'h671A561D;
      total++; if ({lat, en, wr} !== {32'd1, 32'd1, 32'd1}) begin bad++; $display("FAIL store0_timing: got lat=%0d en=%0d wr=%0d want 1 1 1", lat, en, wr); end
      total++; if (rd !== last_load) begin bad++; $display("FAIL store0_rdata: got %h want %h", rd, last_load); end
      xact(1'b1, 16'd1, 32'hFFFFFFFF, 4'hF, lat, en, wr, rd);
      exp_mem[1] = 32'hFFFFFFFF;
      total++; if ({lat, en, wr} !== {32'd1, 32'd1, 32'd1}) begin bad++; $display("FAIL store1_timing: got lat=%0d en=%0d wr=%0d want 1 1 1", lat, en, wr); end
      total++; if ({mem[0], mem[1]} !== {32'h671A561D, 32'hFFFFFFFF}) begin bad++; $display("FAIL store_mem: got %h %h want 671a561d ffffffff", mem[0], mem[1]); end
   endtask

   task automatic test_load();
      int lat, en, wr; logic [31:0] rd;
      xact(1'b0, 16'd1, 32'h0, 4'hF, lat, en, wr, rd);
      last_load = 32'hFFFFFFFF;
      total++; if (rd !== 32'hFFFFFFFF) begin bad++; $display("FAIL load1_rdata: got %h want ffffffff", rd); end
      total++; if ({lat, en, wr} !== {32'd1, 32'd1, 32'd0}) begin bad++; $display("FAIL load1_timing: got lat=%0d en=%0d wr=%0d want 1 1 0", lat, en, wr); end
   endtask

   task automatic test_mask();
      int lat, en, wr; logic [31:0] rd, want;
      int want_lat, want_en;
`ifdef RAM_CTRL_BYTE_MASK_EN
      want = 32'h67BB56DD; want_lat = 2; want_en = 2;
`else
      want = 32'hAABBCCDD; want_lat = 1; want_en = 1;
`endif
      xact(1'b1, 16'd0, 32'hAABBCCDD, 4'b0101, lat, en, wr, rd);
      exp_mem[0] = want;
      total++; if (mem[0] !== want) begin bad++; $display("FAIL mask_mem0: got %h want %h", mem[0], want); end
      total++; if (lat !== want_lat || en !== want_en || wr !== 1) begin bad++; $display("FAIL mask_timing: got lat=%0d en=%0d wr=%0d want %0d %0d 1", lat, en, wr, want_lat, want_en); end
      total++; if (rd !== last_load) begin bad++; $display("FAIL mask_rdata: got %h want %h", rd, last_load); end
   endtask

   task automatic test_zero_mask();
      int lat, en, wr; logic [31:0] rd, want;
      int want_en;
`ifdef RAM_CTRL_BYTE_MASK_EN
      want = 32'h0; want_en = 0;
`else
      want = 32'h5555AAAA; want_en = 1;
`endif
      xact(1'b1, 16'd2, 32'h5555AAAA, 4'b0000, lat, en, wr, rd);
      exp_mem[2] = want;
      total++; if (mem[2] !== want) begin bad++; $display("FAIL zmask_mem2: got %h want %h", mem[2], want); end
      total++; if (lat !== 1 || en !== want_en) begin bad++; $display("FAIL zmask_timing: got lat=%0d en=%0d want 1 %0d", lat, en, want_en); end
   endtask

   task automatic test_backpressure();
      bit seen;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_address = 16'd0; rsp_ready = 1'b0;
      @(posedge clk); #1 req_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      total++; if (!seen) begin bad++; $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid"); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if ({rsp_valid, req_ready} !== 2'b10 || rsp_rdata !== exp_mem[0]) begin
            bad++; $display("FAIL bp_hold%0d: got v=%b rdy=%b d=%h want 1 0 %h", c, rsp_valid, req_ready, rsp_rdata, exp_mem[0]);
         end
      end
      last_load = exp_mem[0];
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_address = 16'd1;
      @(posedge clk); #1;
      @(negedge clk);
      total++; if ({req_ready, ram_enable, rsp_valid} !== 3'b100) begin bad++; $display("FAIL bp_idle_gap: got %b want 100", {req_ready, ram_enable, rsp_valid}); end
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      total++; if ({ram_enable, ram_read_write, ram_address} !== {2'b11, 16'd1}) begin bad++; $display("FAIL bp_next_access: got %b %h want 11 0001", {ram_enable, ram_read_write}, ram_address); end
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_mem[1]) begin bad++; $display("FAIL bp_next_rsp: got v=%b d=%h want 1 %h", rsp_valid, rsp_rdata, exp_mem[1]); end
      last_load = exp_mem[1];
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat, en, wr; logic [31:0] rd, d, want;
      logic w; logic [15:0] a; logic [3:0] m;
      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom_range(0, 1));
         a = 16'($urandom_range(0, 15));
         d = $urandom;
         m = 4'($urandom_range(0, 15));
         xact(w, a, d, m, lat, en, wr, rd);
         want = w ? last_load : exp_mem[a];
         if (w) exp_mem[a] = merge(exp_mem[a], d, m);
         else last_load = exp_mem[a];
         total++;
         if (rd !== want || lat !== exp_lat(w, m) || en !== exp_en(w, m) || mem[a] !== exp_mem[a]) begin
            bad++;
            $display("FAIL rand%0d w=%b a=%0d m=%h: got rd=%h lat=%0d en=%0d mem=%h want %h %0d %0d %h",
                     n, w, a, m, rd, lat, en, mem[a], want, exp_lat(w, m), exp_en(w, m), exp_mem[a]);
         end
      end
      for (int i = 0; i < 16; i++) begin
         total++;
         if (mem[i] !== exp_mem[i]) begin bad++; $display("FAIL rand_final_mem%0d: got %h want %h", i, mem[i], exp_mem[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_abort();
      test_full_store();
      test_load();
      test_mask();
      test_zero_mask();
      test_backpressure();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ram_controller.md
# ram_controller

Request/response front end for the `Ram` block. It accepts one word read or write at a time from the CPU datapath over a valid/ready handshake and drives the Ram's `enable`, `read_write`, `address` and `data_in` pins with registered, single-cycle access strobes. It captures `data_out` on reads and returns it over a valid/ready response channel. With byte masking compiled in, it turns partial-word stores into read-modify-write sequences.

## Interface
- DATA_SIZE, 32, Ram word width; must be a multiple of 8
- ADDRESS_SIZE, 16, Ram word-address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state and outputs
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_address  in  ADDRESS_SIZE  word address
- req_wdata  in  DATA_SIZE  store data
- req_mask  in  DATA_SIZE/8  byte enables; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_SIZE  load data
- ram_enable  out  1  to Ram `enable`
- ram_read_write  out  1  to Ram `read_write`; 0 = write, 1 = read
- ram_address  out  ADDRESS_SIZE  to Ram `address`
- ram_data_in  out  DATA_SIZE  to Ram `data_in`
- ram_data_out  in  DATA_SIZE  from Ram `data_out`

## Operation
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, latch write, address, wdata and mask.
  - Load or full-mask store goes to ACCESS.
  - Partial, non-zero mask store goes to RMW_RD.
  - Zero-mask store goes to RESP with no Ram access.
- ACCESS:
  - ram_enable=1, ram_read_write=~write, ram_address/ram_data_in = latched values.
  - Next state is RESP.
  - For a load, rsp_rdata <= ram_data_out at the edge leaving ACCESS.
- RMW_RD:
  - ram_enable=1, ram_read_write=1.
  - At the exit edge, compute merged word: per byte, mask bit 1 takes wdata, 0 takes ram_data_out.
  - Next state is RMW_WR.
- RMW_WR:
  - ram_enable=1, ram_read_write=0, ram_data_in = merged word.
  - Next state is RESP.
- RESP:
  - rsp_valid=1, held stable until rsp_ready is sampled high, then IDLE.
  - rsp_rdata is unchanged by stores, i.e. it holds the last load value.
- Between accesses: ram_enable=0, ram_read_write=1, ram_address and ram_data_in hold their last values. No write strobe is possible outside ACCESS or RMW_WR.
- Reset values: req_ready=0 while reset is high, then 1. All other outputs are 0 except ram_read_write=1.
- Reset mid-operation aborts the sequence and drops ram_enable immediately. A partially completed RMW leaves the Ram unmodified if reset arrives during RMW_RD.

## Timing
- Request accepted at edge E0. ram_enable is high for exactly one cycle per Ram access.
- Load or full store: access during cycle E0–E1, rsp_valid from E1. Best-case turnaround is 3 cycles (request, access, response), with req_ready high again one cycle after the response handshake.
- RMW store: read during E0–E1, write during E1–E2, rsp_valid from E2.
- Zero-mask store: rsp_valid from E1, ram_enable never asserted.
- There is no request pipelining; req_ready is low from E0 until the edge after the rsp handshake.
- Back-pressure: rsp_ready low holds RESP indefinitely, with rsp_rdata stable.
- Simultaneous rsp handshake and new req_valid: the new request is not accepted until IDLE, one cycle later.

## Configuration
- RAM_CTRL_BYTE_MASK_EN
  - Defined: req_mask is honoured as described, and states RMW_RD and RMW_WR exist.
  - Undefined: req_mask is ignored, every store is a single-cycle full-word write via ACCESS, and the RMW states and merge logic are not compiled.

## Test plan
- Reset is asserted mid-ACCESS of a store to 16'd3. Required: ram_enable drops asynchronously, mem[3] keeps its prior value, req_ready=1 after reset releases.
- Store 32'h671A561D to 16'd0, then store 32'hFFFFFFFF to 16'd1 (full masks). Required: each has ram_enable high for one cycle with ram_read_write=0, rsp_valid one cycle after acceptance, and `$writememb` of Ram.mem shows both words.
- Load 16'd1 after the previous step. Required: rsp_rdata=32'hFFFFFFFF and rsp_valid one cycle after acceptance.
- With the macro defined: mem[0]=32'h671A561D, then store 32'hAABBCCDD with mask 4'b0101. Required: read cycle then write cycle, mem[0]=32'h67BB56DD, rsp_valid two cycles after acceptance.
- With the macro defined: store with mask 4'b0000. Required: ram_enable stays 0 and rsp_valid rises one cycle after acceptance. With the macro undefined, the same store writes the full word.
- Hold rsp_ready=0 for 5 cycles during a load response. Required: rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a new request is accepted the cycle after rsp_ready goes high.
